stepper_spi_arbiter: RTL

Round-robin SPI master that shares one serial link between NUM_DEV stepper driver chips. Each requester presents a fixed-width datagram. The block grants the link to one requester at a time, frames the transfer with that chip's select, and shifts the datagram out MSB first while capturing the chip's reply. It sits between the per-axis motion logic and the driver pins, and replaces free-running divider, PISO and SIPO chains with one sequenced, arbitrated transfer engine.

---
 rtl/stepper_spi_pkg.sv | 15 +
 rtl/spi_phase_timer.sv | 34 +++
 rtl/stepper_spi_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/stepper_spi_pkg.sv
// Shared types and defaults for the arbitrated stepper-driver SPI master.
package stepper_spi_pkg;

  localparam int DEF_NUM_DEV = 4;
  localparam int DEF_WIDTH   = 40;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Reloadable SCK phase counter: one-cycle tick at the end of every phase of period+1 cycles.
module spi_phase_timer
  import stepper_spi_pkg::*;
#(
  parameter int DIV_SIZE = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                load,
  input  logic [DIV_SIZE-1:0] period,
  output logic                tick
);

  logic [DIV_SIZE-1:0] cnt;
  logic [DIV_SIZE-1:0] per;

  // The period is captured on load so later divider changes cannot disturb a transfer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
      per <= '0;
    end else if (load) begin
      cnt <= period;
      per <= period;
    end else if (cnt == '0) begin
      cnt <= per;
    end else begin
      cnt <= cnt - DIV_SIZE'(1);
    end
  end

  assign tick = (cnt == '0) && !load;

endmodule

// File: rtl/stepper_spi_arbiter.sv
// Round-robin SPI master sharing one link between NUM_DEV stepper drivers (mode 0, MSB first).
module stepper_spi_arbiter
  import stepper_spi_pkg::*;
#(
  parameter int NUM_DEV  = DEF_NUM_DEV,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DIV_SIZE = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [DIV_SIZE-1:0]      clk_div_in,
  input  logic [NUM_DEV-1:0]       req_in,
  input  logic [NUM_DEV*WIDTH-1:0] data_in,
  input  logic                     miso_in,
  output logic                     sck_out,
  output logic                     mosi_out,
  output logic [NUM_DEV-1:0]       cs_n_out,
  output logic [NUM_DEV-1:0]       ack_out,
  output logic [WIDTH-1:0]         rdata_out,
  output logic                     busy_out
);

  localparam int IDX_W  = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int BCNT_W = $clog2(2*WIDTH+1);
  localparam logic [BCNT_W-1:0] LAST_PHASE = BCNT_W'(2*WIDTH);
  localparam logic [BCNT_W-1:0] LAST_FALL  = BCNT_W'(2*WIDTH-1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_DEV-1);

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    sel;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_vld;
  logic [WIDTH-1:0]    grant_data;
  logic [WIDTH-1:0]    tx;
  logic [WIDTH-1:0]    rx;
  logic [BCNT_W-1:0]   bcnt;
  logic                tick;
  logic                shift_tick;
  logic                rise;
  logic                fall_shift;

  // Scan downward from pointer+NUM_DEV-1 so the requester nearest the pointer is written last and wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_DEV-1; i >= 0; i--) begin
      if (req_in[IDX_W'((int'(ptr) + i) % NUM_DEV)]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'((int'(ptr) + i) % NUM_DEV);
      end
    end
    if (state != IDLE) grant_vld = 1'b0;
  end

  assign grant_data = data_in[grant_idx*WIDTH +: WIDTH];

  spi_phase_timer #(
    .DIV_SIZE(DIV_SIZE)
  ) u_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (grant_vld),
    .period (clk_div_in),
    .tick   (tick)
  );

  // bcnt numbers the SHIFT phase in progress (1..2*WIDTH); sck is high in odd phases.
  assign shift_tick = (state == SHIFT) && tick;
  assign rise       = ((state == SETUP) && tick)
                    || (shift_tick && !sck_out && (bcnt != LAST_PHASE));
  assign fall_shift = shift_tick && sck_out && (bcnt != LAST_FALL);

  always_ff @(posedge clk_in) begin
    if (grant_vld) begin
      tx <= grant_data;
    end else if (fall_shift) begin
      tx <= {tx[WIDTH-2:0], 1'b0};
    end
    if (rise) begin
      rx <= {rx[WIDTH-2:0], miso_in};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      bcnt      <= '0;
      sck_out   <= 1'b0;
      mosi_out  <= 1'b0;
      cs_n_out  <= '1;
      ack_out   <= '0;
      rdata_out <= '0;
    end else begin
      ack_out <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            state    <= SETUP;
            sel      <= grant_idx;
            ptr      <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
            cs_n_out <= ~(NUM_DEV'(1) << grant_idx);
            mosi_out <= grant_data[WIDTH-1];
          end
        end
        SETUP: begin
          if (tick) begin
            state   <= SHIFT;
            sck_out <= 1'b1;
            bcnt    <= BCNT_W'(1);
          end
        end
        SHIFT: begin
          if (tick) begin
            if (bcnt == LAST_PHASE) begin
              state <= HOLD;
            end else begin
              bcnt    <= bcnt + BCNT_W'(1);
              sck_out <= ~sck_out;
              if (fall_shift) mosi_out <= tx[WIDTH-2];
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state     <= GAP;
            cs_n_out  <= '1;
            mosi_out  <= 1'b0;
            ack_out   <= NUM_DEV'(1) << sel;
            rdata_out <= rx;
          end
        end
        GAP: begin
          if (tick) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_out = (state != IDLE);

endmodule
